fnd_scan_controller: RTL and testbench

Sequential front end for the 4-digit FND display. Converts a 14-bit binary value to four BCD digits with an iterative shift-add-3 engine, holds the result, and time-multiplexes the digits onto the shared segment bus. Each cycle it presents one BCD nibble on `o_bcd`, which feeds the BCD-to-FND font decoder, and drives the matching active-low digit select.

---
 rtl/fnd_scan_if.sv | 31 +++
 rtl/fnd_scan_controller.sv | 129 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Control/status bundle between a display client and the FND scan controller.
// The client drives start/value; the controller returns status, digits and scan outputs.
interface fnd_scan_if;
    logic        i_start;
    logic [13:0] i_value;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_digitsBcd;
    logic [3:0]  o_bcd;
    logic [3:0]  o_fndDigit;

    modport master (
        output i_start,
        output i_value,
        input  o_busy,
        input  o_done,
        input  o_digitsBcd,
        input  o_bcd,
        input  o_fndDigit
    );

    modport slave (
        input  i_start,
        input  i_value,
        output o_busy,
        output o_done,
        output o_digitsBcd,
        output o_bcd,
        output o_fndDigit
    );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD converter (iterative shift-add-3) feeding a 4-digit multiplexed FND scanner.
// Holds the last converted value and walks one digit slot every SCAN_DIV clocks.
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic      i_clk,
    input  logic      i_reset,
    fnd_scan_if.slave bus
);
    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [13:0]     VALUE_MAX = 14'd9999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [13:0]      src_reg;
    logic [15:0]      acc_reg;
    logic [3:0]       bit_cnt_reg;
    logic [15:0]      digits_reg;
    logic [CNT_W-1:0] div_reg;
    logic [1:0]       index_reg;

    logic [15:0]      acc_adj;
    logic [29:0]      shift_next;
    logic [13:0]      value_sat;
    logic [3:0]       nib_zero;
    logic [3:0]       lead_zero;
    logic [3:0]       cur_nibble;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.i_start) state_next = CONVERT;
            CONVERT: if (bit_cnt_reg == 4'd13) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        bus.o_busy = (state_reg != IDLE);
        bus.o_done = (state_reg == DONE);
    end

    // Per-nibble add-3 correction and leading-zero detection on the held digits
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
            assign nib_zero[gi]  = (digits_reg[gi*4 +: 4] == 4'd0);
            assign lead_zero[gi] = &nib_zero[3:gi];
        end
    endgenerate

    assign shift_next = {acc_adj, src_reg} << 1;
    assign value_sat  = (bus.i_value > VALUE_MAX) ? VALUE_MAX : bus.i_value;

    // Conversion datapath
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            src_reg     <= '0;
            acc_reg     <= '0;
            bit_cnt_reg <= '0;
            digits_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_start) begin
                        src_reg     <= value_sat;
                        acc_reg     <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                CONVERT: begin
                    acc_reg     <= shift_next[29:14];
                    src_reg     <= shift_next[13:0];
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
                DONE: begin
                    digits_reg <= acc_reg;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan prescaler; runs regardless of conversion activity
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_reg   <= '0;
            index_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg   <= '0;
            index_reg <= index_reg + 2'd1;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign cur_nibble      = digits_reg[{index_reg, 2'b00} +: 4];
    assign bus.o_digitsBcd = digits_reg;

    // Scan outputs; the ones digit is never blanked
    always_comb begin
        bus.o_fndDigit = ~(4'b0001 << index_reg);
        bus.o_bcd      = cur_nibble;
        if (BLANK_LZ && (index_reg != 2'd0) && lead_zero[index_reg]) begin
            bus.o_bcd = 4'hf;
        end
    end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: two instances (blanking on/off) with SCAN_DIV = 4.
// Each task drives one scenario and compares against hand-computed values.
module tb_fnd_scan_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fnd_scan_if bus0 ();
    fnd_scan_if bus1 ();

    fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1)
    );

    typedef struct {
        int          sel;
        logic [13:0] value;
        logic [15:0] exp_bcd;   // {slot3, slot2, slot1, slot0}
    } blank_case_t;

    task automatic drive(input int sel, input logic start, input logic [13:0] value);
        if (sel == 0) begin
            bus0.i_start = start;
            bus0.i_value = value;
        end else begin
            bus1.i_start = start;
            bus1.i_value = value;
        end
    endtask

    function automatic logic [3:0] fnd_of(input int sel);
        return (sel == 0) ? bus0.o_fndDigit : bus1.o_fndDigit;
    endfunction

    function automatic logic [3:0] bcd_of(input int sel);
        return (sel == 0) ? bus0.o_bcd : bus1.o_bcd;
    endfunction

    function automatic logic [15:0] digits_of(input int sel);
        return (sel == 0) ? bus0.o_digitsBcd : bus1.o_digitsBcd;
    endfunction

    // Full conversion: one-cycle start, then wait until the result is held.
    task automatic run_conv(input int sel, input logic [13:0] value);
        @(negedge clk);
        drive(sel, 1'b1, value);
        @(negedge clk);
        drive(sel, 1'b0, value);
        repeat (15) @(negedge clk);
        $display("conv dut%0d value=%0d digits=%h", sel, value, digits_of(sel));
    endtask

    // Stops on the first sample of slot 0 (digit select just went 0111 -> 1110).
    task automatic sync_slot0(input int sel, output bit ok);
        logic [3:0] prev;
        logic [3:0] cur;
        ok   = 1'b0;
        prev = fnd_of(sel);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            cur = fnd_of(sel);
            if (prev == 4'b0111 && cur == 4'b1110) begin
                ok = 1'b1;
                break;
            end
            prev = cur;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 14'd0);
        drive(1, 1'b0, 14'd0);
        #12;
        n_checks++;
        if (bus0.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus0.o_busy); end
        n_checks++;
        if (bus0.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus0.o_done); end
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got=%h want=0000", bus0.o_digitsBcd); end
        n_checks++;
        if (bus0.o_fndDigit !== 4'b1110) begin n_fail++; $display("FAIL reset_fnd got=%b want=1110", bus0.o_fndDigit); end
        n_checks++;
        if (bus0.o_bcd !== 4'h0) begin n_fail++; $display("FAIL reset_bcd got=%h want=0", bus0.o_bcd); end
        @(negedge clk);
        rst = 1'b0;
        // Prescaler starts at 0: slot 0 lasts exactly 4 clocks after release
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.o_fndDigit !== ((k < 4) ? 4'b1110 : 4'b1101)) begin
                n_fail++;
                $display("FAIL reset_prescale k=%0d got=%b want=%b", k, bus0.o_fndDigit, (k < 4) ? 4'b1110 : 4'b1101);
            end
        end
    endtask

    task automatic test_convert_1234;
        @(negedge clk);
        drive(0, 1'b1, 14'd1234);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) drive(0, 1'b0, 14'd0);   // later value changes must not matter
            n_checks++;
            if (bus0.o_busy !== 1'b1) begin n_fail++; $display("FAIL conv_busy k=%0d got=%b want=1", k, bus0.o_busy); end
            n_checks++;
            if (bus0.o_done !== (k == 14)) begin n_fail++; $display("FAIL conv_done k=%0d got=%b want=%b", k, bus0.o_done, (k == 14)); end
        end
        @(negedge clk);
        n_checks++;
        if (bus0.o_busy !== 1'b0) begin n_fail++; $display("FAIL conv_busy_end got=%b want=0", bus0.o_busy); end
        n_checks++;
        if (bus0.o_done !== 1'b0) begin n_fail++; $display("FAIL conv_done_end got=%b want=0", bus0.o_done); end
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h1234) begin n_fail++; $display("FAIL conv_1234 got=%h want=1234", bus0.o_digitsBcd); end
        $display("conv dut0 value=1234 digits=%h", bus0.o_digitsBcd);
    endtask

    task automatic test_scan;
        bit         ok;
        logic [3:0] exp_bcd [4];
        int         idx;
        exp_bcd = '{4'h4, 4'h3, 4'h2, 4'h1};
        sync_slot0(0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL scan_sync got=timeout want=slot0"); end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            idx = (k / 4) % 4;
            n_checks++;
            if (bus0.o_fndDigit !== ~(4'b0001 << idx)) begin
                n_fail++;
                $display("FAIL scan_fnd k=%0d got=%b want=%b", k, bus0.o_fndDigit, ~(4'b0001 << idx));
            end
            n_checks++;
            if (bus0.o_bcd !== exp_bcd[idx]) begin
                n_fail++;
                $display("FAIL scan_bcd k=%0d got=%h want=%h", k, bus0.o_bcd, exp_bcd[idx]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [13:0] vals [5];
        logic [15:0] exps [5];
        vals = '{14'd16383, 14'd9999, 14'd0, 14'd10000, 14'd1};
        exps = '{16'h9999, 16'h9999, 16'h0000, 16'h9999, 16'h0001};
        for (int i = 0; i < 5; i++) begin
            run_conv(0, vals[i]);
            n_checks++;
            if (bus0.o_digitsBcd !== exps[i]) begin
                n_fail++;
                $display("FAIL sat value=%0d got=%h want=%h", vals[i], bus0.o_digitsBcd, exps[i]);
            end
        end
    endtask

    task automatic test_blanking;
        blank_case_t cases [5];
        bit          ok;
        int          idx;
        logic [15:0] e;
        cases[0] = '{0, 14'd7,    16'hfff7};
        cases[1] = '{0, 14'd0,    16'hfff0};
        cases[2] = '{0, 14'd1020, 16'h1020};
        cases[3] = '{0, 14'd90,   16'hff90};
        cases[4] = '{1, 14'd7,    16'h0007};
        for (int c = 0; c < 5; c++) begin
            run_conv(cases[c].sel, cases[c].value);
            sync_slot0(cases[c].sel, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL blank_sync case=%0d got=timeout want=slot0", c); end
            e = cases[c].exp_bcd;
            for (int k = 0; k < 16; k++) begin
                if (k > 0) @(negedge clk);
                idx = k / 4;
                n_checks++;
                if (bcd_of(cases[c].sel) !== e[idx*4 +: 4]) begin
                    n_fail++;
                    $display("FAIL blank case=%0d value=%0d slot=%0d got=%h want=%h",
                             c, cases[c].value, idx, bcd_of(cases[c].sel), e[idx*4 +: 4]);
                end
            end
        end
    endtask

    task automatic test_start_during_convert;
        int dones = 0;
        @(negedge clk);
        drive(0, 1'b1, 14'd42);
        @(negedge clk);
        drive(0, 1'b0, 14'd42);
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 14'd5555);
        @(negedge clk);
        drive(0, 1'b0, 14'd5555);
        for (int k = 0; k < 25; k++) begin
            if (bus0.o_done === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL abuse_dones got=%0d want=1", dones); end
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0042) begin n_fail++; $display("FAIL abuse_digits got=%h want=0042", bus0.o_digitsBcd); end
        n_checks++;
        if (bus0.o_busy !== 1'b0) begin n_fail++; $display("FAIL abuse_busy got=%b want=0", bus0.o_busy); end
        $display("conv dut0 value=42 (start 5555 ignored) digits=%h", bus0.o_digitsBcd);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(0, 1'b1, 14'd321);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) drive(0, 1'b0, 14'd321);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0321) begin n_fail++; $display("FAIL b2b_first got=%h want=0321", bus0.o_digitsBcd); end
        drive(0, 1'b1, 14'd678);
        @(negedge clk);
        drive(0, 1'b0, 14'd678);
        n_checks++;
        if (bus0.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b want=1", bus0.o_busy); end
        repeat (14) @(negedge clk);
        n_checks++;
        if (bus0.o_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b want=1", bus0.o_done); end
        @(negedge clk);
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0678) begin n_fail++; $display("FAIL b2b_second got=%h want=0678", bus0.o_digitsBcd); end
        $display("conv dut0 back-to-back 321,678 digits=%h", bus0.o_digitsBcd);
    endtask

    task automatic test_reset_mid_convert;
        int dones = 0;
        @(negedge clk);
        drive(0, 1'b1, 14'd4321);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) drive(0, 1'b0, 14'd4321);
            if (bus0.o_done === 1'b1) dones++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_digits got=%h want=0000", bus0.o_digitsBcd); end
        n_checks++;
        if (bus0.o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", bus0.o_busy); end
        n_checks++;
        if (bus0.o_fndDigit !== 4'b1110) begin n_fail++; $display("FAIL midrst_fnd got=%b want=1110", bus0.o_fndDigit); end
        n_checks++;
        if (bus0.o_bcd !== 4'h0) begin n_fail++; $display("FAIL midrst_bcd got=%h want=0", bus0.o_bcd); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.o_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL midrst_dones got=%0d want=0", dones); end
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_after got=%h want=0000", bus0.o_digitsBcd); end
        $display("conv dut0 value=4321 abandoned by reset digits=%h", bus0.o_digitsBcd);
    endtask

    task automatic test_fresh_after_reset;
        run_conv(0, 14'd8765);
        n_checks++;
        if (bus0.o_digitsBcd !== 16'h8765) begin n_fail++; $display("FAIL fresh got=%h want=8765", bus0.o_digitsBcd); end
        run_conv(1, 14'd305);
        n_checks++;
        if (bus1.o_digitsBcd !== 16'h0305) begin n_fail++; $display("FAIL fresh_dut1 got=%h want=0305", bus1.o_digitsBcd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_convert_1234();
        test_scan();
        test_saturation();
        test_blanking();
        test_start_during_convert();
        test_back_to_back();
        test_reset_mid_convert();
        test_fresh_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
